// File: rtl/sprite_pkg.sv
// Shared types and helpers for the sprite index fetch stage.
//   anim_state_t        : animation controller states
//   TRANSPARENT_IDX_DEF : default see-through palette index
//   spr_addr()          : ROM word address of pixel (dx, dy) in animation frame 'frame'
package sprite_pkg;

  typedef enum logic [1:0] {
    StStop,
    StRun,
    StHold
  } anim_state_t;

  localparam logic [3:0] TRANSPARENT_IDX_DEF = 4'd0;

  // Frames are stored back to back, each one row-major.
  function automatic logic [31:0] spr_addr(input logic [31:0] frame,
                                           input logic [31:0] dy,
                                           input logic [31:0] dx,
                                           input logic [31:0] spr_w,
                                           input logic [31:0] spr_h);
    return frame * spr_w * spr_h + dy * spr_w + dx;
  endfunction

endpackage

// File: rtl/sprite_anim_ctrl.sv
// Animation frame sequencer for a single sprite.
//   Clk, Reset_n : pixel clock, synchronous active-low reset
//   vsync_fall   : one-cycle strobe, start of a new video frame
//   anim_en      : 1 = animation running
//   oneshot      : 1 = stop on the last frame, 0 = loop
//   frame        : current animation frame
//   anim_done    : one-cycle pulse when a oneshot run lands on the last frame
module sprite_anim_ctrl
  import sprite_pkg::*;
#(
  parameter int unsigned FRAMES      = 4,
  parameter int unsigned FRAME_TICKS = 6,
  parameter int unsigned FRAME_W     = (FRAMES > 1) ? $clog2(FRAMES) : 1
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               vsync_fall,
  input  logic               anim_en,
  input  logic               oneshot,
  output logic [FRAME_W-1:0] frame,
  output logic               anim_done
);

  localparam int unsigned TickW = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
  localparam logic [FRAME_W-1:0] LastFrame = FRAME_W'(FRAMES - 1);
  localparam logic [TickW-1:0]   LastTick  = TickW'(FRAME_TICKS - 1);

  anim_state_t        state_q;
  logic [FRAME_W-1:0] frame_q;
  logic [TickW-1:0]   tick_q;
  logic               done_q;

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q <= StStop;
      frame_q <= '0;
      tick_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StStop: begin
          frame_q <= '0;
          tick_q  <= '0;
          // A vsync edge in the same cycle is deliberately not counted.
          if (anim_en) state_q <= StRun;
        end
        StRun: begin
          if (vsync_fall && anim_en) begin
            if (tick_q != LastTick) begin
              tick_q <= tick_q + 1'b1;
            end else begin
              tick_q <= '0;
              if (frame_q == LastFrame) begin
                // Only reachable with oneshot low, or oneshot raised late.
                if (oneshot) begin
                  done_q  <= 1'b1;
                  state_q <= StHold;
                end else begin
                  frame_q <= '0;
                end
              end else begin
                frame_q <= frame_q + 1'b1;
                if (oneshot && ((frame_q + 1'b1) == LastFrame)) begin
                  done_q  <= 1'b1;
                  state_q <= StHold;
                end
              end
            end
          end
        end
        StHold: begin
          if (!anim_en) begin
            state_q <= StStop;
            frame_q <= '0;
            tick_q  <= '0;
          end
        end
        default: state_q <= StStop;
      endcase
    end
  end

  assign frame     = frame_q;
  assign anim_done = done_q;

endmodule

// File: rtl/sprite_index_fetch.sv
// Sprite hit test and index ROM fetch, three pipeline registers from DrawX/DrawY to outputs.
//   Clk, Reset_n        : pixel clock, synchronous active-low reset
//   DrawX, DrawY, blank : current pixel and active-video flag
//   vsync               : active-low vertical sync
//   SpriteX, SpriteY    : sprite top-left, latched on vsync fall
//   anim_en, oneshot    : animation control
//   rom_addr, rom_q     : synchronous index ROM port (1-cycle read latency)
//   index, sprite_on    : palette index and opaque-pixel flag
//   DrawX_d, DrawY_d, blank_d : coordinates aligned with index
//   anim_done           : oneshot completion pulse
module sprite_index_fetch
  import sprite_pkg::*;
#(
  parameter int unsigned SPR_W           = 32,
  parameter int unsigned SPR_H           = 32,
  parameter int unsigned FRAMES          = 4,
  parameter int unsigned FRAME_TICKS     = 6,
  parameter logic [3:0]  TRANSPARENT_IDX = TRANSPARENT_IDX_DEF,
  parameter int unsigned ADDR_W          = $clog2(SPR_W * SPR_H * FRAMES)
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic              blank,
  input  logic              vsync,
  input  logic [9:0]        SpriteX,
  input  logic [9:0]        SpriteY,
  input  logic              anim_en,
  input  logic              oneshot,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [3:0]        rom_q,
  output logic [3:0]        index,
  output logic              sprite_on,
  output logic [9:0]        DrawX_d,
  output logic [9:0]        DrawY_d,
  output logic              blank_d,
  output logic              anim_done
);

  localparam int unsigned FrameW = (FRAMES > 1) ? $clog2(FRAMES) : 1;
  localparam logic [10:0] SprW11 = 11'(SPR_W);
  localparam logic [10:0] SprH11 = 11'(SPR_H);

  logic              vsync_q, vsync_fall;
  logic [9:0]        sx_q, sy_q;
  logic [FrameW-1:0] frame;
  logic [10:0]       dx, dy;
  logic              hit;
  logic [ADDR_W-1:0] rom_addr_d, rom_addr_q;

  logic       hit1_q, hit2_q;
  logic [9:0] x1_q, y1_q, x2_q, y2_q, x3_q, y3_q;
  logic       b1_q, b2_q, b3_q;
  logic [3:0] index_q;
  logic       on_q;

  assign vsync_fall = vsync_q & ~vsync;

  // 11-bit subtraction: a pixel left of / above the sprite wraps large and misses.
  assign dx  = {1'b0, DrawX} - {1'b0, sx_q};
  assign dy  = {1'b0, DrawY} - {1'b0, sy_q};
  assign hit = blank & (dx < SprW11) & (dy < SprH11);

  always_comb begin
    rom_addr_d = '0;
    if (hit) begin
      rom_addr_d = ADDR_W'(spr_addr(32'(frame), 32'(dy), 32'(dx), SPR_W, SPR_H));
    end
  end

  sprite_anim_ctrl #(
    .FRAMES      (FRAMES),
    .FRAME_TICKS (FRAME_TICKS),
    .FRAME_W     (FrameW)
  ) u_anim (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .vsync_fall (vsync_fall),
    .anim_en    (anim_en),
    .oneshot    (oneshot),
    .frame      (frame),
    .anim_done  (anim_done)
  );

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      vsync_q    <= 1'b1;
      sx_q       <= '0;
      sy_q       <= '0;
      rom_addr_q <= '0;
      hit1_q     <= 1'b0;
      x1_q       <= '0;
      y1_q       <= '0;
      b1_q       <= 1'b0;
      hit2_q     <= 1'b0;
      x2_q       <= '0;
      y2_q       <= '0;
      b2_q       <= 1'b0;
      index_q    <= TRANSPARENT_IDX;
      on_q       <= 1'b0;
      x3_q       <= '0;
      y3_q       <= '0;
      b3_q       <= 1'b0;
    end else begin
      vsync_q <= vsync;
      if (vsync_fall) begin
        sx_q <= SpriteX;
        sy_q <= SpriteY;
      end
      // Stage 1: address and hit.
      rom_addr_q <= rom_addr_d;
      hit1_q     <= hit;
      x1_q       <= DrawX;
      y1_q       <= DrawY;
      b1_q       <= blank;
      // Stage 2: ROM read in flight, carry the side-band along.
      hit2_q     <= hit1_q;
      x2_q       <= x1_q;
      y2_q       <= y1_q;
      b2_q       <= b1_q;
      // Stage 3: registered outputs.
      index_q    <= hit2_q ? rom_q : TRANSPARENT_IDX;
      on_q       <= hit2_q & (rom_q != TRANSPARENT_IDX);
      x3_q       <= x2_q;
      y3_q       <= y2_q;
      b3_q       <= b2_q;
    end
  end

  assign rom_addr  = rom_addr_q;
  assign index     = index_q;
  assign sprite_on = on_q;
  assign DrawX_d   = x3_q;
  assign DrawY_d   = y3_q;
  assign blank_d   = b3_q;

endmodule

// File: tb/tb_sprite_index_fetch.sv
// Self-checking bench for sprite_index_fetch: directed table, corner sequences, random run
// against a behavioural model (frame derived arithmetically from a count of vsync falls).
module tb_sprite_index_fetch;

  localparam int SPR_W  = 32;
  localparam int SPR_H  = 32;
  localparam int FRAMES = 4;
  localparam int FT     = 6;
  localparam int AW     = 12;

  logic          Clk = 1'b0;
  logic          Reset_n = 1'b0;
  logic [9:0]    DrawX = '0, DrawY = '0, SpriteX = '0, SpriteY = '0;
  logic          blank = 1'b0, vsync = 1'b1, anim_en = 1'b0, oneshot = 1'b0;
  logic [AW-1:0] rom_addr;
  logic [3:0]    rom_q, index;
  logic          sprite_on, blank_d, anim_done;
  logic [9:0]    DrawX_d, DrawY_d;

  logic [3:0] mem [4096];

  always #5 Clk = ~Clk;
  always @(posedge Clk) rom_q <= mem[rom_addr];

  sprite_index_fetch dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .DrawX     (DrawX),
    .DrawY     (DrawY),
    .blank     (blank),
    .vsync     (vsync),
    .SpriteX   (SpriteX),
    .SpriteY   (SpriteY),
    .anim_en   (anim_en),
    .oneshot   (oneshot),
    .rom_addr  (rom_addr),
    .rom_q     (rom_q),
    .index     (index),
    .sprite_on (sprite_on),
    .DrawX_d   (DrawX_d),
    .DrawY_d   (DrawY_d),
    .blank_d   (blank_d),
    .anim_done (anim_done)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [3:0]    idx;
    logic          on;
    logic [9:0]    x;
    logic [9:0]    y;
    logic          b;
  } exp_t;

  typedef struct {
    int         sx, sy, x, y;
    bit         bl;
    logic [11:0] addr;
    logic [3:0] idx;
    bit         on;
  } vec_t;

  exp_t e0, e1, e2, ezero;
  int   msx, msy, cnt;
  bit   mrun, mheld, mprev_vs, mdone;
  int   n_tests = 0, n_fail = 0, pulses = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int mframe();
    if (oneshot) return (cnt / FT >= FRAMES - 1) ? FRAMES - 1 : cnt / FT;
    return (cnt / FT) % FRAMES;
  endfunction

  // One clock: drive inputs, advance the model, then compare after the edge.
  task automatic step(input bit rst_n, input bit vs, input bit bl, input int x, input int y);
    int   dx, dy, f;
    bit   hit, fall;
    exp_t n;
    @(negedge Clk);
    Reset_n = rst_n;
    vsync   = vs;
    blank   = bl;
    DrawX   = x[9:0];
    DrawY   = y[9:0];
    if (!rst_n) begin
      e0 = ezero; e1 = ezero; e2 = ezero;
      msx = 0; msy = 0; cnt = 0;
      mrun = 0; mheld = 0; mprev_vs = 1; mdone = 0;
    end else begin
      dx  = x - msx;
      dy  = y - msy;
      hit = bl && dx >= 0 && dx < SPR_W && dy >= 0 && dy < SPR_H;
      f   = mframe();
      n.addr = hit ? AW'(f * SPR_W * SPR_H + dy * SPR_W + dx) : '0;
      n.idx  = hit ? mem[n.addr] : 4'd0;
      n.on   = hit && (n.idx != 4'd0);
      n.x    = x[9:0];
      n.y    = y[9:0];
      n.b    = bl;
      e2 = e1; e1 = e0; e0 = n;
      fall = mprev_vs && !vs;
      mprev_vs = vs;
      if (fall) begin msx = SpriteX; msy = SpriteY; end
      mdone = 0;
      if (!mrun) begin
        cnt = 0;
        if (anim_en) mrun = 1;
      end else if (mheld) begin
        if (!anim_en) begin mrun = 0; mheld = 0; cnt = 0; end
      end else if (fall && anim_en) begin
        cnt++;
        if (oneshot && cnt / FT >= FRAMES - 1) begin mheld = 1; mdone = 1; end
      end
    end
    @(posedge Clk);
    #1;
    if (anim_done === 1'b1) pulses++;
    chk("rom_addr", 32'(rom_addr), 32'(e0.addr));
    chk("index", 32'(index), 32'(e2.idx));
    chk("sprite_on", 32'(sprite_on), 32'(e2.on));
    chk("DrawX_d", 32'(DrawX_d), 32'(e2.x));
    chk("DrawY_d", 32'(DrawY_d), 32'(e2.y));
    chk("blank_d", 32'(blank_d), 32'(e2.b));
    chk("anim_done", 32'(anim_done), 32'(mdone));
  endtask

  task automatic do_reset();
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
  endtask

  task automatic latch_pos(input int sx, input int sy);
    SpriteX = sx[9:0];
    SpriteY = sy[9:0];
    step(1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0);
  endtask

  vec_t tbl[12];

  initial begin
    ezero = '{addr: '0, idx: '0, on: 1'b0, x: '0, y: '0, b: 1'b0};
    for (int a = 0; a < 4096; a++) mem[a] = 4'((a * 5 + 5) % 16);

    tbl[0]  = '{100, 50, 100, 50, 1, 12'd0, 4'd5, 1};
    tbl[1]  = '{100, 50, 99, 50, 1, 12'd0, 4'd0, 0};
    tbl[2]  = '{100, 50, 132, 50, 1, 12'd0, 4'd0, 0};
    tbl[3]  = '{100, 50, 131, 50, 1, 12'd31, 4'd0, 0};
    tbl[4]  = '{100, 50, 100, 81, 1, 12'd992, 4'd5, 1};
    tbl[5]  = '{100, 50, 100, 82, 1, 12'd0, 4'd0, 0};
    tbl[6]  = '{100, 50, 100, 50, 0, 12'd0, 4'd0, 0};
    tbl[7]  = '{620, 10, 639, 10, 1, 12'd19, 4'd4, 1};
    tbl[8]  = '{620, 470, 630, 10, 1, 12'd0, 4'd0, 0};
    tbl[9]  = '{620, 470, 630, 479, 1, 12'd298, 4'd7, 1};
    tbl[10] = '{1000, 1000, 1023, 1023, 1, 12'd759, 4'd8, 1};
    tbl[11] = '{1000, 0, 5, 5, 1, 12'd0, 4'd0, 0};

    do_reset();
    chk("reset_index", 32'(index), 32'd0);
    chk("reset_on", 32'(sprite_on), 32'd0);

    // Directed hit-test table, frame 0, animation stopped.
    for (int i = 0; i < 12; i++) begin
      latch_pos(tbl[i].sx, tbl[i].sy);
      step(1, 1, tbl[i].bl, tbl[i].x, tbl[i].y);
      chk("tbl_addr", 32'(rom_addr), 32'(tbl[i].addr));
      step(1, 1, 0, 0, 0);
      step(1, 1, 0, 0, 0);
      chk("tbl_index", 32'(index), 32'(tbl[i].idx));
      chk("tbl_on", 32'(sprite_on), 32'(tbl[i].on));
      chk("tbl_x", 32'(DrawX_d), 32'(tbl[i].x));
    end

    // Mid-frame position change is ignored until the next vsync fall.
    latch_pos(100, 50);
    SpriteX = 10'd200;
    step(1, 1, 1, 105, 50);
    chk("old_x_hit", 32'(rom_addr), 32'd5);
    step(1, 0, 0, 0, 0);
    step(1, 1, 1, 105, 50);
    chk("new_x_miss", 32'(rom_addr), 32'd0);
    step(1, 1, 1, 205, 50);
    chk("new_x_hit", 32'(rom_addr), 32'd5);

    // Reset mid-line flushes the pipeline.
    latch_pos(100, 50);
    step(1, 1, 1, 100, 50);
    step(1, 1, 1, 100, 50);
    step(0, 1, 1, 100, 50);
    chk("rst_addr", 32'(rom_addr), 32'd0);
    chk("rst_index", 32'(index), 32'd0);
    chk("rst_on", 32'(sprite_on), 32'd0);
    chk("rst_x", 32'(DrawX_d), 32'd0);
    step(1, 1, 1, 0, 0);
    step(1, 1, 1, 0, 0);
    chk("post_rst_flush", 32'(sprite_on), 32'd0);
    step(1, 1, 1, 0, 0);
    chk("post_rst_on", 32'(sprite_on), 32'd1);
    chk("post_rst_index", 32'(index), 32'd5);

    // Loop mode: anim_en rises on a vsync edge, which is not counted.
    do_reset();
    latch_pos(100, 50);
    anim_en = 1'b1;
    step(1, 0, 1, 100, 50);
    for (int i = 1; i <= 24; i++) begin
      step(1, 1, 1, 100, 50);
      step(1, 0, 1, 100, 50);
      step(1, 1, 1, 100, 50);
      if (i == 5) chk("loop_f5", 32'(rom_addr), 32'd0);
      if (i % 6 == 0) chk("loop_frame", 32'(rom_addr), 32'(((i / 6) % 4) * 1024));
    end

    // Oneshot: lands on frame 3 after 18 falls, single pulse, hold, then stop.
    anim_en = 1'b0;
    do_reset();
    oneshot = 1'b1;
    latch_pos(100, 50);
    anim_en = 1'b1;
    step(1, 1, 1, 100, 50);
    pulses = 0;
    for (int i = 1; i <= 24; i++) begin
      step(1, 1, 1, 100, 50);
      step(1, 0, 1, 100, 50);
      if (i == 18) chk("os_done", 32'(anim_done), 32'd1);
      step(1, 1, 1, 100, 50);
      if (i == 18) chk("os_frame3", 32'(rom_addr), 32'd3072);
    end
    chk("os_pulses", 32'(pulses), 32'd1);
    chk("os_hold", 32'(rom_addr), 32'd3072);
    anim_en = 1'b0;
    step(1, 1, 1, 100, 50);
    step(1, 1, 1, 100, 50);
    chk("os_stop", 32'(rom_addr), 32'd0);

    // Randomised run in loop mode.
    oneshot = 1'b0;
    do_reset();
    anim_en = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      int x, y;
      if ($urandom_range(0, 199) == 0) begin
        SpriteX = 10'($urandom_range(0, 1023));
        SpriteY = 10'($urandom_range(0, 1023));
      end
      if ($urandom_range(0, 49) == 0) anim_en = ~anim_en;
      if ($urandom_range(0, 3) == 0) begin
        x = $urandom_range(0, 1023);
        y = $urandom_range(0, 1023);
      end else begin
        x = (msx + $urandom_range(0, 40) + 1020) % 1024;
        y = (msy + $urandom_range(0, 40) + 1020) % 1024;
      end
      step(1, $urandom_range(0, 9) != 0, $urandom_range(0, 4) != 0, x, y);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
